// File: rtl/multi_pwm.sv
// Multi-channel PWM generator that shares one counter across all channels.
// Settings are double-buffered and only take effect at a period boundary, or at once when idle.
`timescale 1ns / 1ps
module multi_pwm #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       pwm_enable,
  input  logic [7:0]              pwm_prescale,
  input  logic [WIDTH-1:0]        pwm_period,
  input  logic                    pwm_center,
  input  logic [NUM_CH*WIDTH-1:0] pwm_duty,
  input  logic                    pwm_update,
  output logic                    pwm_done,
  output logic                    pwm_period_start,
  output logic [NUM_CH-1:0]       pwm_signal
);

  localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

  typedef enum logic {DirUp, DirDown} dir_e;

  // Shadow settings, written by pwm_update.
  logic [7:0]              sh_prescale_q, sh_prescale_d;
  logic [WIDTH-1:0]        sh_period_q, sh_period_d;
  logic                    sh_center_q, sh_center_d;
  logic [NUM_CH*WIDTH-1:0] sh_duty_q, sh_duty_d;
  logic                    pending_q, pending_d;

  // Active settings, driving the counter and comparators.
  logic [7:0]              act_prescale_q, act_prescale_d;
  logic [WIDTH-1:0]        act_period_q, act_period_d;
  logic                    act_center_q, act_center_d;
  logic [NUM_CH*WIDTH-1:0] act_duty_q, act_duty_d;

  logic [7:0]        presc_q, presc_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  dir_e              dir_q, dir_d;
  logic              tick, boundary, apply;
  logic              applied_q;
  logic              done_q, period_start_q;
  logic [NUM_CH-1:0] signal_q, signal_d;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_prescale_q  <= '0;
      sh_period_q    <= '1;
      sh_center_q    <= 1'b0;
      sh_duty_q      <= '0;
      pending_q      <= 1'b0;
      act_prescale_q <= '0;
      act_period_q   <= '1;
      act_center_q   <= 1'b0;
      act_duty_q     <= '0;
      presc_q        <= '0;
      cnt_q          <= '0;
      dir_q          <= DirUp;
      applied_q      <= 1'b0;
      done_q         <= 1'b0;
      period_start_q <= 1'b0;
      signal_q       <= '0;
    end else begin
      sh_prescale_q  <= sh_prescale_d;
      sh_period_q    <= sh_period_d;
      sh_center_q    <= sh_center_d;
      sh_duty_q      <= sh_duty_d;
      pending_q      <= pending_d;
      act_prescale_q <= act_prescale_d;
      act_period_q   <= act_period_d;
      act_center_q   <= act_center_d;
      act_duty_q     <= act_duty_d;
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      applied_q      <= apply;
      done_q         <= applied_q;
      period_start_q <= boundary;
      signal_q       <= signal_d;
    end
  end

  // Prescaler and period counter next state.
  always_comb begin
    tick     = (presc_q == act_prescale_q);
    presc_d  = tick ? 8'd0 : presc_q + 8'd1;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    boundary = 1'b0;
    if (tick) begin
      if (act_period_q == '0) begin
        cnt_d    = '0;
        dir_d    = DirUp;
        boundary = 1'b1;
      end else if (!act_center_q) begin
        if (cnt_q >= act_period_q) begin
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end else if (dir_q == DirUp) begin
        if (cnt_q >= act_period_q) begin
          // With P==1 the peak is also the last tick of the period.
          if (act_period_q == CntOne) begin
            cnt_d    = '0;
            boundary = 1'b1;
          end else begin
            cnt_d = act_period_q - CntOne;
            dir_d = DirDown;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end else begin
        if (cnt_q <= CntOne) begin
          cnt_d    = '0;
          dir_d    = DirUp;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
    end

    // Idle channels allow applying without waiting for a boundary.
    apply = pending_q && (boundary || (pwm_enable == '0));
    if (apply) begin
      presc_d = '0;
      cnt_d   = '0;
      dir_d   = DirUp;
    end
  end

  // Shadow capture and active load; an update on the apply edge stays pending.
  always_comb begin
    sh_prescale_d  = sh_prescale_q;
    sh_period_d    = sh_period_q;
    sh_center_d    = sh_center_q;
    sh_duty_d      = sh_duty_q;
    act_prescale_d = act_prescale_q;
    act_period_d   = act_period_q;
    act_center_d   = act_center_q;
    act_duty_d     = act_duty_q;
    pending_d      = pwm_update | (pending_q & ~apply);
    if (pwm_update) begin
      sh_prescale_d = pwm_prescale;
      sh_period_d   = pwm_period;
      sh_center_d   = pwm_center;
      sh_duty_d     = pwm_duty;
    end
    if (apply) begin
      act_prescale_d = sh_prescale_q;
      act_period_d   = sh_period_q;
      act_center_d   = sh_center_q;
      act_duty_d     = sh_duty_q;
    end
  end

  // Per-channel duty comparators.
  always_comb begin
    signal_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      signal_d[i] = pwm_enable[i] & (cnt_q < act_duty_q[i*WIDTH +: WIDTH]);
    end
  end

  assign pwm_done         = done_q;
  assign pwm_period_start = period_start_q;
  assign pwm_signal       = signal_q;

endmodule

// File: tb/tb_multi_pwm.sv
// Directed bench for multi_pwm: table of settings with hand-computed high counts per window,
// plus cycle-exact sequences for apply timing, deferred update and mid-period reset.
`timescale 1ns / 1ps
module tb_multi_pwm;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;

  logic                    clock = 1'b0;
  logic                    reset_n;
  logic [NUM_CH-1:0]       pwm_enable;
  logic [7:0]              pwm_prescale;
  logic [WIDTH-1:0]        pwm_period;
  logic                    pwm_center;
  logic [NUM_CH*WIDTH-1:0] pwm_duty;
  logic                    pwm_update;
  logic                    pwm_done;
  logic                    pwm_period_start;
  logic [NUM_CH-1:0]       pwm_signal;

  multi_pwm #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .pwm_enable       (pwm_enable),
    .pwm_prescale     (pwm_prescale),
    .pwm_period       (pwm_period),
    .pwm_center       (pwm_center),
    .pwm_duty         (pwm_duty),
    .pwm_update       (pwm_update),
    .pwm_done         (pwm_done),
    .pwm_period_start (pwm_period_start),
    .pwm_signal       (pwm_signal)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  presc;
    logic [7:0]  period;
    logic        center;
    logic [31:0] duty;
    logic [3:0]  en;
    int          win;
    int          h0, h1, h2, h3;
    int          ps;
  } vec_t;

  vec_t        vecs[6];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          hi[4];
  int          ps_cnt, done_cnt, done_at, old_hi, new_hi, ch3_hi;
  logic [19:0] got_sig, exp_sig, got_ps, exp_ps;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic program_cfg(input logic [7:0] ps, input logic [7:0] p, input logic c,
                             input logic [31:0] d);
    pwm_prescale = ps;
    pwm_period   = p;
    pwm_center   = c;
    pwm_duty     = d;
    pwm_update   = 1'b1;
    step();
    pwm_update   = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!pwm_done && k < 20) begin
      step();
      k++;
    end
    if (!pwm_done) check(name, 0, 1);
  endtask

  task automatic wait_ps(input string name);
    int k;
    k = 0;
    while (!pwm_period_start && k < 600) begin
      step();
      k++;
    end
    if (!pwm_period_start) check(name, 0, 1);
  endtask

  task automatic count_window(input int win);
    for (int c = 0; c < 4; c++) hi[c] = 0;
    ps_cnt   = 0;
    done_cnt = 0;
    for (int k = 0; k < win; k++) begin
      step();
      for (int c = 0; c < 4; c++) hi[c] += int'(pwm_signal[c]);
      ps_cnt   += int'(pwm_period_start);
      done_cnt += int'(pwm_done);
    end
  endtask

  initial begin
    // presc, P, center, {d3,d2,d1,d0}, enable, window, highs ch0..3, period starts
    vecs[0] = '{8'd0, 8'd9, 1'b0, {8'd12, 8'd0, 8'd5, 8'd3}, 4'b1111, 20, 6, 10, 0, 20, 2};
    vecs[1] = '{8'd1, 8'd9, 1'b0, {8'd0, 8'd10, 8'd9, 8'd3}, 4'b1111, 40, 12, 36, 40, 0, 2};
    vecs[2] = '{8'd0, 8'd4, 1'b1, {8'd5, 8'd4, 8'd2, 8'd0}, 4'b1111, 16, 0, 6, 14, 16, 2};
    vecs[3] = '{8'd2, 8'd0, 1'b0, {8'd1, 8'd1, 8'd0, 8'd1}, 4'b1011, 12, 12, 0, 0, 12, 4};
    vecs[4] = '{8'd0, 8'd1, 1'b1, {8'd0, 8'd0, 8'd2, 8'd1}, 4'b1111, 8, 4, 8, 0, 0, 4};
    vecs[5] = '{8'd1, 8'd3, 1'b1, {8'd2, 8'd4, 8'd1, 8'd3}, 4'b1111, 24, 20, 4, 24, 12, 2};

    reset_n      = 1'b0;
    pwm_enable   = '0;
    pwm_prescale = '0;
    pwm_period   = '0;
    pwm_center   = 1'b0;
    pwm_duty     = '0;
    pwm_update   = 1'b0;
    step();
    step();
    check("rst_signal", int'(pwm_signal), 0);
    check("rst_done", int'(pwm_done), 0);
    check("rst_period_start", int'(pwm_period_start), 0);
    reset_n = 1'b1;
    step();

    // Idle apply: done two clocks after the update edge.
    program_cfg(8'd0, 8'd9, 1'b0, {8'd0, 8'd0, 8'd0, 8'd3});
    check("a_done_e1", int'(pwm_done), 0);
    step();
    check("a_done_e2", int'(pwm_done), 0);
    step();
    check("a_done_e3", int'(pwm_done), 1);
    step();
    check("a_done_e4", int'(pwm_done), 0);
    pwm_enable = 4'b0001;
    wait_ps("a_wait_ps");
    for (int j = 1; j <= 20; j++) begin
      step();
      got_sig[j-1] = pwm_signal[0];
      got_ps[j-1]  = pwm_period_start;
      exp_sig[j-1] = ((j - 1) % 10) < 3;
      exp_ps[j-1]  = (j % 10) == 0;
    end
    check("a_sig_pattern", int'(got_sig), int'(exp_sig));
    check("a_ps_pattern", int'(got_ps), int'(exp_ps));

    for (int i = 0; i < 6; i++) begin
      pwm_enable = '0;
      step();
      program_cfg(vecs[i].presc, vecs[i].period, vecs[i].center, vecs[i].duty);
      wait_done($sformatf("v%0d_done", i));
      pwm_enable = vecs[i].en;
      step();
      step();
      count_window(vecs[i].win);
      check($sformatf("v%0d_ch0_high", i), hi[0], vecs[i].h0);
      check($sformatf("v%0d_ch1_high", i), hi[1], vecs[i].h1);
      check($sformatf("v%0d_ch2_high", i), hi[2], vecs[i].h2);
      check($sformatf("v%0d_ch3_high", i), hi[3], vecs[i].h3);
      check($sformatf("v%0d_period_start", i), ps_cnt, vecs[i].ps);
    end

    // Two updates mid-period: only the last one lands, at the boundary.
    pwm_enable = '0;
    step();
    program_cfg(8'd0, 8'd9, 1'b0, {8'd12, 8'd0, 8'd0, 8'd3});
    wait_done("b_done_setup");
    pwm_enable = 4'b1001;
    wait_ps("b_wait_ps");
    old_hi   = 0;
    new_hi   = 0;
    ch3_hi   = 0;
    done_cnt = 0;
    done_at  = 0;
    for (int j = 1; j <= 30; j++) begin
      step();
      if (j <= 10) old_hi += int'(pwm_signal[0]);
      else new_hi += int'(pwm_signal[0]);
      ch3_hi += int'(pwm_signal[3]);
      if (pwm_done) begin
        done_cnt++;
        done_at = j;
      end
      pwm_update = 1'b0;
      if (j == 4 || j == 6) begin
        pwm_duty   = {8'd12, 8'd0, 8'd0, (j == 4) ? 8'd5 : 8'd7};
        pwm_update = 1'b1;
      end
    end
    check("b_old_high", old_hi, 3);
    check("b_new_high", new_hi, 14);
    check("b_done_count", done_cnt, 1);
    check("b_done_at", done_at, 11);
    check("b_ch3_high", ch3_hi, 30);

    // Reset at cnt=5 with an update pending.
    wait_ps("c_wait_ps");
    step();
    step();
    pwm_duty   = {8'd12, 8'd0, 8'd0, 8'd9};
    pwm_update = 1'b1;
    step();
    pwm_update = 1'b0;
    step();
    step();
    check("c_pre_signal", int'(pwm_signal), 4'b1001);
    reset_n = 1'b0;
    #1;
    check("c_rst_signal", int'(pwm_signal), 0);
    check("c_rst_done", int'(pwm_done), 0);
    check("c_rst_period_start", int'(pwm_period_start), 0);
    pwm_enable = '0;
    step();
    step();
    reset_n = 1'b1;
    count_window(10);
    check("c_idle_done", done_cnt, 0);
    pwm_enable = 4'b1111;
    count_window(512);
    check("c_post_high", hi[0] + hi[1] + hi[2] + hi[3], 0);
    check("c_post_period_start", ps_cnt, 2);
    check("c_post_done", done_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
